io_controller: RTL and testbench

- Memory-mapped I/O peripheral behind the data-memory address decoder; selected when the decoder asserts pRead/pWrite for the I/O region.
- Debounces two push buttons and snapshots the 16 slide switches on a btnR press.
- Drives a 12-bit LED/display value written by the CPU and acknowledged by btnL.
- Exposes status, switch, and LED registers through a word-indexed register map.

---
 rtl/io_controller_if.sv | 25 ++
 rtl/io_controller.sv | 136 +++++++++++++
 tb/tb_io_controller.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_controller_if.sv
// CPU-side bus of the I/O peripheral: decoder selects, register index and data.
// The master drives the strobes. The peripheral returns readData combinationally.
interface io_controller_if;
  logic        pRead;
  logic        pWrite;
  logic [1:0]  addr;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport master (
    output pRead,
    output pWrite,
    output addr,
    output writeData,
    input  readData
  );

  modport slave (
    input  pRead,
    input  pWrite,
    input  addr,
    input  writeData,
    output readData
  );
endinterface

// File: rtl/io_controller.sv
// Memory-mapped I/O peripheral: debounced buttons, switch snapshot on btnR,
// CPU-written LED value acknowledged by btnL, word-indexed status/data map.
module io_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  io_controller_if.slave    bus,
  input  logic              btnL,
  input  logic              btnR,
  input  logic [15:0]       switch,
  output logic [11:0]       led
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_SWITCH = 2'd1;
  localparam logic [1:0] ADDR_LED    = 2'd2;
  localparam logic [1:0] ADDR_LEDRB  = 2'd3;

  // index 0 = btnL, index 1 = btnR
  logic [1:0] btn_raw;
  logic [1:0] btn_press;

  assign btn_raw = {btnR, btnL};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             level_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             differ;
      logic             expire;

      assign differ = (sync2_reg != level_reg);
      assign expire = differ && (cnt_reg == CNT_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          level_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (expire) begin
            level_reg <= ~level_reg;
            cnt_reg   <= '0;
          end else if (differ) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      // Press is the same edge on which the level rises, so consumers act on it directly.
      assign btn_press[gi] = expire && !level_reg;
    end
  endgenerate

  logic [15:0] sw_sync1_reg;
  logic [15:0] sw_sync2_reg;
  logic [15:0] sw_reg;
  logic        sw_ready_reg;
  logic        overrun_reg;
  logic [11:0] led_reg;
  logic        led_ready_reg;

  logic rd_status;
  logic rd_switch;
  logic wr_led;
  logic unused_wdata;

  assign rd_status    = bus.pRead  && (bus.addr == ADDR_STATUS);
  assign rd_switch    = bus.pRead  && (bus.addr == ADDR_SWITCH);
  assign wr_led       = bus.pWrite && (bus.addr == ADDR_LED);
  assign unused_wdata = ^bus.writeData[31:12];

  // Event-set takes priority over read-clear; an LED write beats a same-edge ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync1_reg  <= '0;
      sw_sync2_reg  <= '0;
      sw_reg        <= '0;
      sw_ready_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
      led_reg       <= '0;
      led_ready_reg <= 1'b1;
    end else begin
      sw_sync1_reg <= switch;
      sw_sync2_reg <= sw_sync1_reg;

      if (btn_press[1]) begin
        sw_reg       <= sw_sync2_reg;
        sw_ready_reg <= 1'b1;
      end else if (rd_switch) begin
        sw_ready_reg <= 1'b0;
      end

      if (btn_press[1] && sw_ready_reg) begin
        overrun_reg <= 1'b1;
      end else if (rd_status) begin
        overrun_reg <= 1'b0;
      end

      if (wr_led) begin
        led_reg       <= bus.writeData[11:0];
        led_ready_reg <= 1'b0;
      end else if (btn_press[0]) begin
        led_ready_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.readData = '0;
    if (bus.pRead) begin
      case (bus.addr)
        ADDR_STATUS: bus.readData = {29'b0, overrun_reg, led_ready_reg, sw_ready_reg};
        ADDR_SWITCH: bus.readData = {16'b0, sw_reg};
        ADDR_LED:    bus.readData = '0;
        ADDR_LEDRB:  bus.readData = {20'b0, led_reg};
        default:     bus.readData = '0;
      endcase
    end
  end

  assign led = led_reg;

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: a history-based reference model checked every
// cycle, plus literal expectations from the documented scenarios.
module tb_io_controller;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btnL = 1'b0;
  logic        btnR = 1'b0;
  logic [15:0] switch = 16'h0;
  logic [11:0] led;

  io_controller_if bus();

  io_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .btnL   (btnL),
    .btnR   (btnR),
    .switch (switch),
    .led    (led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: raw input histories (newest first) and architectural registers
  bit          hist_r[$];
  bit          hist_l[$];
  logic [15:0] hist_sw[$];
  bit          m_lvl_r = 1'b0, m_lvl_l = 1'b0;
  logic [15:0] m_sw_reg = 16'h0;
  bit          m_sw_ready = 1'b0, m_overrun = 1'b0, m_led_ready = 1'b1;
  logic [11:0] m_led_reg = 12'h0;
  bit          ev_r, ev_l, flip_r, flip_l, old_ready;
  logic [15:0] sw_sample;

  // The debounced level flips once the synchronized input (raw delayed two edges)
  // has disagreed with it for D consecutive edges.
  function automatic bit settled(input bit h[$], input bit lvl);
    if (h.size() < D + 1) return 1'b0;
    for (int i = 1; i <= D; i++)
      if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_r.delete(); hist_l.delete(); hist_sw.delete();
      m_lvl_r = 1'b0; m_lvl_l = 1'b0;
      m_sw_reg = 16'h0; m_sw_ready = 1'b0; m_overrun = 1'b0;
      m_led_reg = 12'h0; m_led_ready = 1'b1;
    end else begin
      flip_r = settled(hist_r, m_lvl_r);
      flip_l = settled(hist_l, m_lvl_l);
      ev_r = flip_r && !m_lvl_r;
      ev_l = flip_l && !m_lvl_l;
      if (flip_r) m_lvl_r = !m_lvl_r;
      if (flip_l) m_lvl_l = !m_lvl_l;
      sw_sample = (hist_sw.size() >= 2) ? hist_sw[1] : 16'h0;
      old_ready = m_sw_ready;

      if (ev_r) begin
        m_sw_reg = sw_sample;
        m_sw_ready = 1'b1;
        if (old_ready) m_overrun = 1'b1;
        else if (bus.pRead && bus.addr == 2'd0) m_overrun = 1'b0;
      end else begin
        if (bus.pRead && bus.addr == 2'd1) m_sw_ready = 1'b0;
        if (bus.pRead && bus.addr == 2'd0) m_overrun = 1'b0;
      end

      if (bus.pWrite && bus.addr == 2'd2) begin
        m_led_reg = bus.writeData[11:0];
        m_led_ready = 1'b0;
      end else if (ev_l) begin
        m_led_ready = 1'b1;
      end

      hist_r.push_front(btnR);
      hist_l.push_front(btnL);
      hist_sw.push_front(switch);
      if (hist_r.size() > D + 2) void'(hist_r.pop_back());
      if (hist_l.size() > D + 2) void'(hist_l.pop_back());
      if (hist_sw.size() > D + 2) void'(hist_sw.pop_back());
    end
  end

  function automatic logic [31:0] model_read();
    if (!bus.pRead) return 32'h0;
    case (bus.addr)
      2'd0:    return {29'b0, m_overrun, m_led_ready, m_sw_ready};
      2'd1:    return {16'b0, m_sw_reg};
      2'd3:    return {20'b0, m_led_reg};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_readData", bus.readData, model_read());
    check("model_led", {20'b0, led}, {20'b0, m_led_reg});
  end

  // All stimulus changes happen 2 time units after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic read_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.pRead = 1'b1;
    bus.addr = a;
    @(negedge clk);
    check(name, bus.readData, exp);
    $display("read  addr=%0d data=%h", a, bus.readData);
    @(posedge clk);
    #2;
    bus.pRead = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    bus.pWrite = 1'b1;
    bus.addr = a;
    bus.writeData = d;
    $display("write addr=%0d data=%h", a, d);
    @(posedge clk);
    #2;
    bus.pWrite = 1'b0;
  endtask

  // Holds a STATUS read while btnR is high and reports on which falling edge bit0 rises.
  // First sampling edge k precedes falling edge 2; the event at edge k+5 shows on falling edge 7.
  task automatic count_event(input int exp, input string name);
    int first = 0;
    bus.pRead = 1'b1;
    bus.addr = 2'd0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (first == 0 && bus.readData[0]) first = i;
    end
    check(name, first, exp);
    $display("event %s seen at falling edge %0d", name, first);
    @(posedge clk);
    #2;
    bus.pRead = 1'b0;
  endtask

  initial begin
    bus.pRead = 1'b0;
    bus.pWrite = 1'b0;
    bus.addr = 2'd0;
    bus.writeData = 32'h0;
    cycles(3);
    reset = 1'b0;

    read_chk(2'd0, 32'h2, "reset_status");
    read_chk(2'd1, 32'h0, "reset_switch");
    check("reset_led", {20'b0, led}, 32'h0);

    switch = 16'hA5C3;
    cycles(3);
    btnR = 1'b1;
    count_event(7, "btnr_latency");
    read_chk(2'd1, 32'h0000A5C3, "switch_snapshot");
    read_chk(2'd0, 32'h2, "switch_read_clears_ready");
    btnR = 1'b0;
    cycles(10);
    read_chk(2'd0, 32'h2, "release_no_event");

    btnR = 1'b1;
    cycles(3);
    btnR = 1'b0;
    cycles(10);
    read_chk(2'd0, 32'h2, "glitch_no_event");

    write_reg(2'd2, 32'hFFFF_F123);
    @(negedge clk);
    check("led_after_write", {20'b0, led}, 32'h123);
    cycles(1);
    read_chk(2'd0, 32'h0, "led_write_clears_ready");
    read_chk(2'd3, 32'h123, "ledrb");
    read_chk(2'd2, 32'h0, "led_read_zero");
    write_reg(2'd3, 32'h0000_0ABC);
    write_reg(2'd0, 32'h0000_0DEF);
    read_chk(2'd3, 32'h123, "ignored_writes");
    btnL = 1'b1;
    cycles(8);
    btnL = 1'b0;
    cycles(8);
    read_chk(2'd0, 32'h2, "btnl_ack");
    check("led_unchanged_by_ack", {20'b0, led}, 32'h123);

    switch = 16'h0001;
    cycles(3);
    btnR = 1'b1; cycles(8);
    btnR = 1'b0; cycles(8);
    switch = 16'h0002;
    cycles(3);
    btnR = 1'b1; cycles(8);
    btnR = 1'b0; cycles(8);
    read_chk(2'd0, 32'h7, "overrun_status");
    read_chk(2'd1, 32'h2, "overrun_switch");
    read_chk(2'd0, 32'h2, "overrun_cleared");

    // btnR event lands on the same edge as a SWITCH read
    switch = 16'h0BEE;
    cycles(3);
    btnR = 1'b1;
    cycles(5);
    bus.pRead = 1'b1;
    bus.addr = 2'd1;
    @(negedge clk);
    check("same_edge_old_sw", bus.readData, 32'h2);
    cycles(1);
    bus.pRead = 1'b0;
    read_chk(2'd0, 32'h3, "same_edge_ready_kept");
    read_chk(2'd1, 32'h0BEE, "same_edge_new_sw");
    btnR = 1'b0;
    cycles(8);

    // btnL event on the same edge as an LED write: the write wins
    btnL = 1'b1;
    cycles(5);
    write_reg(2'd2, 32'h0000_0456);
    read_chk(2'd0, 32'h0, "write_beats_ack");
    check("led_write_same_edge", {20'b0, led}, 32'h456);
    btnL = 1'b0;
    cycles(8);

    btnR = 1'b1;
    cycles(3);
    reset = 1'b1;
    cycles(1);
    read_chk(2'd0, 32'h2, "in_reset_status");
    check("in_reset_led", {20'b0, led}, 32'h0);
    reset = 1'b0;
    count_event(7, "post_reset_latency");
    read_chk(2'd3, 32'h0, "post_reset_ledrb");
    btnR = 1'b0;
    cycles(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
